// File: rtl/mmio_port_responder.sv
// MMIO responder for the processor data bus.
// It decodes a 32-byte register window that holds the output port,
// the synchronized input port, a sticky change flag, a saturating
// change counter and a control register.
// Read data is combinational, so a single-cycle core can finish a load
// in the same cycle it issues it.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0100,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic                Hit,
  output logic [31:0]         ReadData,
  output logic [31:0]         PortOut,
  output logic                IrqOut
);

  localparam logic [2:0] OFF_PORT_OUT = 3'd0;
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_CHG_CNT  = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;

  logic [31:0]         port_out_reg;
  logic [IN_WIDTH-1:0] s1_reg;
  logic [IN_WIDTH-1:0] s2_reg;
  logic [IN_WIDTH-1:0] s3_reg;
  logic                changed_reg;
  logic [15:0]         chg_cnt_reg;
  logic                irq_en_reg;
  logic                cnt_en_reg;
  logic                irq_reg;

  logic [2:0]          reg_sel;
  logic                wr_en;
  logic                change;
  logic                count_change;
  logic [31:0]         port_in_ext;
  logic                changed_next;
  logic [15:0]         chg_cnt_next;
  logic                unused_addr_bits;

  // The window is 32-byte aligned, so a hit is a match of the upper 27 address bits.
  assign Hit          = (Address[31:5] == BASE_ADDR[31:5]);
  assign reg_sel      = Address[4:2];
  assign wr_en        = Hit & MemWrite;
  assign change       = (s2_reg != s3_reg);
  assign count_change = change & cnt_en_reg;
  // The two lowest address bits do not select anything, because all registers are word-wide.
  assign unused_addr_bits = ^Address[1:0];

  assign PortOut = port_out_reg;
  assign IrqOut  = irq_reg;

  // Zero-extend the synchronized input to bus width. This also works when IN_WIDTH is 32.
  always_comb begin
    port_in_ext                 = '0;
    port_in_ext[IN_WIDTH-1:0]   = s2_reg;
  end

  // Combinational load mux. It returns 0 unless the access is a load that hits the window.
  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      case (reg_sel)
        OFF_PORT_OUT: ReadData = port_out_reg;
        OFF_PORT_IN:  ReadData = port_in_ext;
        OFF_STATUS:   ReadData = {31'd0, changed_reg};
        OFF_CHG_CNT:  ReadData = {16'd0, chg_cnt_reg};
        OFF_CTRL:     ReadData = {30'd0, cnt_en_reg, irq_en_reg};
        default:      ReadData = '0;
      endcase
    end
  end

  // Next values of the change flag and the counter.
  // A new change takes priority over a software clear on the same edge.
  always_comb begin
    changed_next = changed_reg;
    if (wr_en && reg_sel == OFF_STATUS && WriteData[0])
      changed_next = 1'b0;
    if (change)
      changed_next = 1'b1;

    chg_cnt_next = chg_cnt_reg;
    if (wr_en && reg_sel == OFF_CHG_CNT)
      chg_cnt_next = count_change ? 16'd1 : 16'd0;
    else if (count_change && chg_cnt_reg != 16'hFFFF)
      chg_cnt_next = chg_cnt_reg + 16'd1;
  end

  // Input synchronizer (s1, s2). s3 holds the previous s2 value, which is used for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= PortIn;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // Register file updates and the registered interrupt output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_reg <= '0;
      changed_reg  <= 1'b0;
      chg_cnt_reg  <= '0;
      irq_en_reg   <= 1'b0;
      cnt_en_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_en && reg_sel == OFF_PORT_OUT)
        port_out_reg <= WriteData;
      if (wr_en && reg_sel == OFF_CTRL) begin
        irq_en_reg <= WriteData[0];
        cnt_en_reg <= WriteData[1];
      end
      changed_reg <= changed_next;
      chg_cnt_reg <= chg_cnt_next;
      irq_reg     <= changed_reg & irq_en_reg;
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Testbench for mmio_port_responder.
// It runs directed scenarios and then randomized bus traffic.
// The reference model keeps the register state as plain variables.
// It also keeps a short history of sampled PortIn values, newest first.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic        Hit;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
  logic        IrqOut;

  always #5 clk = ~clk;

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .Hit(Hit), .ReadData(ReadData), .PortOut(PortOut), .IrqOut(IrqOut)
  );

  // Reference model state
  logic [31:0] m_port_out;
  logic        m_changed;
  int          m_cnt;
  logic        m_irq_en;
  logic        m_cnt_en;
  logic        m_irq;
  logic [7:0]  m_samp [3];  // PortIn sampled at the last three edges, newest first

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'h1F);
  endfunction

  function automatic logic [31:0] m_reg(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    case (off)
      32'd0:   return m_port_out;
      32'd1:   return {24'd0, m_samp[1]};
      32'd2:   return {31'd0, m_changed};
      32'd3:   return 32'(m_cnt);
      32'd4:   return {30'd0, m_cnt_en, m_irq_en};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata();
    return (m_hit(Address) && MemRead) ? m_reg(Address) : 32'd0;
  endfunction

  task automatic m_reset();
    m_port_out = 0; m_changed = 0; m_cnt = 0;
    m_irq_en = 0; m_cnt_en = 0; m_irq = 0;
    for (int i = 0; i < 3; i++) m_samp[i] = 8'd0;
  endtask

  // Advance one clock edge. The model is computed from the inputs as they
  // stood before the edge. PortOut and IrqOut are checked 1 time unit after the edge.
  task automatic step();
    logic        chg, wr, n_changed, n_irq;
    logic [31:0] off;
    int          n_cnt;
    // A change is seen three edges after sampling, when the 2-edge-old and
    // 3-edge-old samples differ.
    chg = (m_samp[1] != m_samp[2]);
    wr  = m_hit(Address) && MemWrite;
    off = (Address - BASE) >> 2;
    n_irq = m_changed && m_irq_en;
    n_changed = m_changed;
    if (wr && off == 2 && WriteData[0]) n_changed = 0;
    if (chg) n_changed = 1;
    n_cnt = m_cnt;
    if (chg && m_cnt_en && n_cnt < 65535) n_cnt++;
    if (wr && off == 3) n_cnt = (chg && m_cnt_en) ? 1 : 0;
    @(posedge clk);
    if (wr && off == 0) m_port_out = WriteData;
    if (wr && off == 4) begin m_irq_en = WriteData[0]; m_cnt_en = WriteData[1]; end
    m_changed = n_changed;
    m_cnt     = n_cnt;
    m_irq     = n_irq;
    m_samp[2] = m_samp[1];
    m_samp[1] = m_samp[0];
    m_samp[0] = PortIn;
    #1;
    check("PortOut", PortOut, m_port_out);
    check("IrqOut", {31'd0, IrqOut}, {31'd0, m_irq});
  endtask

  task automatic idle();
    Address = 32'd0; WriteData = 32'd0; MemWrite = 0; MemRead = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1; MemRead = 0;
    step();
    idle();
  endtask

  // A load is combinational, so no clock edge is needed.
  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1; MemWrite = 0;
    #1;
    check(tag, ReadData, exp);
    MemRead = 0;
  endtask

  initial begin
    reset = 0; PortIn = 8'hA5; idle(); m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_PortOut", PortOut, 32'd0);
    check("rst_IrqOut", {31'd0, IrqOut}, 32'd0);
    check("rst_ReadData", ReadData, 32'd0);
    rd_check("rst_PORT_IN", BASE + 32'h4, 32'd0);
    reset = 1;
    repeat (3) step();
    rd_check("rel_PORT_IN", BASE + 32'h4, 32'hA5);
    rd_check("rel_STATUS", BASE + 32'h8, 32'd1);

    // Port write and readback, out-of-window store
    wr(BASE, 32'hDEAD_BEEF);
    check("po_write", PortOut, 32'hDEAD_BEEF);
    rd_check("po_read", BASE, 32'hDEAD_BEEF);
    Address = BASE + 32'h20; WriteData = 32'h1234_5678; MemWrite = 1;
    #1;
    check("oow_Hit", {31'd0, Hit}, 32'd0);
    step();
    idle();
    check("oow_PortOut", PortOut, 32'hDEAD_BEEF);

    // Change counting
    PortIn = 8'h00;
    repeat (5) step();
    wr(BASE + 32'h8, 32'd1);
    wr(BASE + 32'hC, 32'd0);
    wr(BASE + 32'h10, 32'd3);
    PortIn = 8'h01; repeat (4) step();
    PortIn = 8'h00; repeat (4) step();
    step();
    rd_check("cnt_two", BASE + 32'hC, 32'd2);
    check("cnt_irq", {31'd0, IrqOut}, 32'd1);
    wr(BASE + 32'h8, 32'd1);
    rd_check("w1c_STATUS", BASE + 32'h8, 32'd0);
    step();
    check("w1c_irq", {31'd0, IrqOut}, 32'd0);

    // A W1C clear that lands on the same edge as a detected change
    PortIn = 8'h01;
    step(); step();
    wr(BASE + 32'h8, 32'd1);
    rd_check("setwins_STATUS", BASE + 32'h8, 32'd1);
    rd_check("setwins_model", BASE + 32'h8, m_reg(BASE + 32'h8));

    // Saturation, then a clear that coincides with a counted change
    repeat (4) step();
    wr(BASE + 32'hC, 32'd0);
    for (int i = 0; i < 65540; i++) begin
      PortIn = ~PortIn;
      step();
    end
    rd_check("sat_CHG_CNT", BASE + 32'hC, 32'h0000_FFFF);
    Address = BASE + 32'hC; WriteData = $urandom; MemWrite = 1; MemRead = 0;
    PortIn = ~PortIn;
    step();
    idle();
    rd_check("clr_coinc_CHG_CNT", BASE + 32'hC, 32'd1);
    repeat (4) step();

    // Decode edge cases
    rd_check("reserved_14", BASE + 32'h14, 32'd0);
    rd_check("unaligned_06", BASE + 32'h6, {24'd0, PortIn});
    Address = BASE; MemRead = 0; MemWrite = 0;
    #1;
    check("noread_Hit", {31'd0, Hit}, 32'd1);
    check("noread_ReadData", ReadData, 32'd0);

    // Reset asserted in the middle of a store
    Address = BASE; WriteData = 32'hCAFE_F00D; MemWrite = 1;
    #2;
    reset = 0;
    #1;
    check("midrst_PortOut", PortOut, 32'd0);
    check("midrst_IrqOut", {31'd0, IrqOut}, 32'd0);
    m_reset();
    idle();
    @(posedge clk);
    #1;
    reset = 1;

    // Randomized traffic checked against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) Address = BASE + 32'($urandom_range(0, 31));
      else Address = $urandom;
      WriteData = $urandom;
      MemWrite  = ($urandom_range(0, 3) == 0);
      MemRead   = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom_range(0, 3));
      #1;
      check("rnd_Hit", {31'd0, Hit}, {31'd0, m_hit(Address)});
      check("rnd_ReadData", ReadData, m_rdata());
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
